mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between two requesters.
- Port 0 is the instruction-fetch path and port 1 is the load/store path of the multicycle core; a loader or debug unit may take either port.
- Sequences each access with a small FSM: grant, one-cycle memory access, registered response with an ack pulse.
- Sits between the requesters and the memory. The memory has a combinational read gated by memRead, a synchronous write on posedge clk, and word addressing via address[31:2].

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb2_grant.sv | 26 ++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and arbitration-mode constants.
// Imported by arb2_grant and mem_port_arbiter.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } state_t;

endpackage

// File: rtl/arb2_grant.sv
// Purpose: combinational 2-way grant decision (round-robin or port-0 priority).
// Latency: zero cycles; no state. Backpressure: none, the caller decides when to take the grant.
// Ports: req0/req1 requests, last_grant previous winner, rr_mode 1=round-robin;
//        gnt_valid any request present, gnt_id winning port.
module arb2_grant (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic rr_mode,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      // Tie: round-robin hands the grant to whoever did not win last time;
      // fixed priority always picks port 0.
      gnt_id = rr_mode & ~last_grant;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between two requesters (0 = fetch, 1 = load/store).
// Latency: req seen in IDLE -> memory access next cycle -> registered ack/rdata the cycle after; one access per 3 cycles.
// Backpressure: a requester holds req and its command stable until its ack pulse; the loser simply waits.
// Ports: clk, rst (sync, active-high); m0_*/m1_* request ports (req, we, addr, wdata in; ack, rdata out);
//        mem_address/mem_writedata/mem_read/mem_write to the memory, mem_readdata back (combinational).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int RR_MODE = ARB_RR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writedata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_readdata
);

  localparam logic RR_EN = (RR_MODE == ARB_RR);

  state_t        state, state_nxt;
  logic          owner;
  logic          last_grant;
  logic          gnt_valid;
  logic          gnt_id;
  logic          owner_we;
  logic [AW-1:0] owner_addr;
  logic [DW-1:0] owner_wdata;

  arb2_grant u_grant (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant),
    .rr_mode    (RR_EN),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Only the owner's command reaches the memory; the other port is ignored.
  assign owner_we    = owner ? m1_we    : m0_we;
  assign owner_addr  = owner ? m1_addr  : m0_addr;
  assign owner_wdata = owner ? m1_wdata : m0_wdata;

  always_comb begin
    state_nxt     = state;
    mem_address   = '0;
    mem_writedata = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    case (state)
      S_IDLE: begin
        if (gnt_valid) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // Not gated by rst: the memory has no reset and completes a write
        // presented on the same edge that resets the arbiter.
        mem_address   = owner_addr;
        mem_writedata = owner_wdata;
        mem_read      = ~owner_we;
        mem_write     = owner_we;
        state_nxt     = S_RESP;
      end
      S_RESP: begin
        // Requests are deliberately not sampled here so a req still high
        // from the just-finished access is not served twice.
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;  // port 0 wins the first tie after reset
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state  <= state_nxt;
      // Acks are high exactly in the RESP cycle that follows ACCESS.
      m0_ack <= (state == S_ACCESS) && !owner;
      m1_ack <= (state == S_ACCESS) &&  owner;
      if (state == S_IDLE && gnt_valid) begin
        owner      <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == S_ACCESS && !owner_we) begin
        if (owner) m1_rdata <= mem_readdata;
        else       m0_rdata <= mem_readdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin and one fixed-priority
// instance driven by the same stimulus, each with its own memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_clr = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;

  logic        r_m0_ack, r_m1_ack, r_mem_read, r_mem_write;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_mem_address, r_mem_writedata, r_mem_readdata;
  logic        f_m0_ack, f_m1_ack, f_mem_read, f_mem_write;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_address, f_mem_writedata, f_mem_readdata;

  logic [31:0] mem_r [0:63];
  logic [31:0] mem_f [0:63];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DW(32), .AW(32), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(r_m0_ack), .m0_rdata(r_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(r_m1_ack), .m1_rdata(r_m1_rdata),
    .mem_address(r_mem_address), .mem_writedata(r_mem_writedata),
    .mem_read(r_mem_read), .mem_write(r_mem_write), .mem_readdata(r_mem_readdata)
  );

  mem_port_arbiter #(.DW(32), .AW(32), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
    .mem_address(f_mem_address), .mem_writedata(f_mem_writedata),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_readdata(f_mem_readdata)
  );

  // Memory models: combinational read gated by mem_read, write on posedge, word addressing.
  assign r_mem_readdata = r_mem_read ? mem_r[r_mem_address[7:2]] : 32'h0;
  assign f_mem_readdata = f_mem_read ? mem_f[f_mem_address[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) begin
        mem_r[i] <= 32'h0;
        mem_f[i] <= 32'h0;
      end
      mem_r[2] <= 32'hDEAD_BEEF;
      mem_f[2] <= 32'hDEAD_BEEF;
    end else begin
      if (r_mem_write) mem_r[r_mem_address[7:2]] <= r_mem_writedata;
      if (f_mem_write) mem_f[f_mem_address[7:2]] <= f_mem_writedata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    tick(); tick();
    rst = 1'b0; mem_clr = 1'b0;
    n_total++; if (dut_rr.state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dut_rr.state); else n_pass++;
    n_total++; if ({r_m0_ack, r_m1_ack} !== 2'b00) $display("FAIL reset_acks: got %b want 00", {r_m0_ack, r_m1_ack}); else n_pass++;
    n_total++; if (r_m0_rdata !== 32'h0 || r_m1_rdata !== 32'h0) $display("FAIL reset_rdata: got %h/%h want 0/0", r_m0_rdata, r_m1_rdata); else n_pass++;
    n_total++; if ({r_mem_read, r_mem_write} !== 2'b00 || r_mem_address !== 32'h0) $display("FAIL reset_mem: got rd/wr %b addr %h want 00 0", {r_mem_read, r_mem_write}, r_mem_address); else n_pass++;
  endtask

  task automatic test_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0008;
    tick();  // ACCESS
    n_total++; if (r_mem_read !== 1'b1 || r_mem_write !== 1'b0) $display("FAIL rd_access_rw: got rd %b wr %b want 1 0", r_mem_read, r_mem_write); else n_pass++;
    n_total++; if (r_mem_address !== 32'h8) $display("FAIL rd_access_addr: got %h want 00000008", r_mem_address); else n_pass++;
    n_total++; if ({r_m0_ack, r_m1_ack} !== 2'b00) $display("FAIL rd_access_ack: got %b want 00", {r_m0_ack, r_m1_ack}); else n_pass++;
    tick();  // RESP
    n_total++; if ({r_m0_ack, r_m1_ack} !== 2'b10) $display("FAIL rd_resp_ack: got %b want 10", {r_m0_ack, r_m1_ack}); else n_pass++;
    n_total++; if (r_m0_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_resp_data: got %h want deadbeef", r_m0_rdata); else n_pass++;
    m0_req = 1'b0;
    tick();  // IDLE
    n_total++; if (r_m0_ack !== 1'b0 || r_m0_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_hold: got ack %b data %h want 0 deadbeef", r_m0_ack, r_m0_rdata); else n_pass++;
  endtask

  task automatic test_write_then_read();
    int wr_cycles = 0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'h1234_5678;
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (r_mem_write) wr_cycles++;
      if (t == 1) begin
        n_total++; if (r_mem_writedata !== 32'h1234_5678 || r_mem_address !== 32'h10) $display("FAIL wr_bus: got %h @ %h want 12345678 @ 00000010", r_mem_writedata, r_mem_address); else n_pass++;
      end
      if (t == 2) begin
        n_total++; if ({r_m0_ack, r_m1_ack} !== 2'b01) $display("FAIL wr_ack: got %b want 01", {r_m0_ack, r_m1_ack}); else n_pass++;
        m1_req = 1'b0; m1_we = 1'b0;
      end
    end
    n_total++; if (wr_cycles !== 1) $display("FAIL wr_cycles: got %0d want 1", wr_cycles); else n_pass++;
    n_total++; if (r_m1_rdata !== 32'h0) $display("FAIL wr_rdata_kept: got %h want 0", r_m1_rdata); else n_pass++;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    tick(); tick();
    n_total++; if (r_m0_ack !== 1'b1 || r_m0_rdata !== 32'h1234_5678) $display("FAIL wr_readback: got ack %b data %h want 1 12345678", r_m0_ack, r_m0_rdata); else n_pass++;
    n_total++; if (r_m1_rdata !== 32'h0) $display("FAIL wr_m1_untouched: got %h want 0", r_m1_rdata); else n_pass++;
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp = {(t == 2 || t == 8), (t == 5 || t == 11)};
      n_total++; if ({r_m0_ack, r_m1_ack} !== exp) $display("FAIL rr_acks_t%0d: got %b want %b", t, {r_m0_ack, r_m1_ack}, exp); else n_pass++;
    end
    n_total++; if (r_m0_rdata !== 32'hDEAD_BEEF || r_m1_rdata !== 32'h1234_5678) $display("FAIL rr_data: got %h/%h want deadbeef/12345678", r_m0_rdata, r_m1_rdata); else n_pass++;
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t <= 11) exp = {(t % 3 == 2), 1'b0};
      else         exp = {1'b0, (t == 14)};
      n_total++; if ({f_m0_ack, f_m1_ack} !== exp) $display("FAIL fp_acks_t%0d: got %b want %b", t, {f_m0_ack, f_m1_ack}, exp); else n_pass++;
      if (t == 11) m0_req = 1'b0;
    end
    n_total++; if (f_m1_rdata !== 32'h1234_5678) $display("FAIL fp_m1_data: got %h want 12345678", f_m1_rdata); else n_pass++;
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_rst_in_access();
    rst = 1'b1; tick(); rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    tick(); tick();
    n_total++; if (r_m0_rdata !== 32'h1234_5678) $display("FAIL rst_pre_data: got %h want 12345678", r_m0_rdata); else n_pass++;
    m0_req = 1'b0;
    tick();
    m0_req = 1'b1; m0_addr = 32'h8;
    tick();  // ACCESS
    n_total++; if (dut_rr.state !== 2'd1) $display("FAIL rst_in_access: got state %0d want 1", dut_rr.state); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (dut_rr.state !== 2'd0) $display("FAIL rst_state: got %0d want 0", dut_rr.state); else n_pass++;
    n_total++; if (r_m0_ack !== 1'b0 || r_m0_rdata !== 32'h0) $display("FAIL rst_clear: got ack %b data %h want 0 0", r_m0_ack, r_m0_rdata); else n_pass++;
    tick();
    n_total++; if (r_mem_read !== 1'b1 || r_m0_ack !== 1'b0) $display("FAIL rst_retry_access: got rd %b ack %b want 1 0", r_mem_read, r_m0_ack); else n_pass++;
    tick();
    n_total++; if (r_m0_ack !== 1'b1 || r_m0_rdata !== 32'hDEAD_BEEF) $display("FAIL rst_retry_resp: got ack %b data %h want 1 deadbeef", r_m0_ack, r_m0_rdata); else n_pass++;
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp;
    // Misaligned address: passed through unchanged, memory uses [31:2] only.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_000B;
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp = (t % 3 == 2);
      n_total++; if ({r_m0_ack, r_m1_ack} !== {exp, 1'b0}) $display("FAIL b2b_ack_t%0d: got %b want %b0", t, {r_m0_ack, r_m1_ack}, exp); else n_pass++;
      if (exp) begin
        n_total++; if ({r_mem_read, r_mem_write} !== 2'b00) $display("FAIL b2b_resp_mem_t%0d: got %b want 00", t, {r_mem_read, r_mem_write}); else n_pass++;
      end
      if (t % 3 == 1) begin
        n_total++; if (r_mem_address !== 32'h0000_000B) $display("FAIL b2b_addr_t%0d: got %h want 0000000b", t, r_mem_address); else n_pass++;
      end
    end
    n_total++; if (r_m0_rdata !== 32'hDEAD_BEEF) $display("FAIL b2b_data: got %h want deadbeef", r_m0_rdata); else n_pass++;
    m0_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_then_read();
    test_round_robin();
    test_fixed_priority();
    test_rst_in_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
